// File: rtl/pool_unit.sv
// Streaming pooling element: reduces every WIN signed samples
// to one max, min or floor-average result behind valid/ready.
module pool_unit #(
  parameter int DATA_W = 16,
  parameter int WIN    = 4,
  parameter int CNT_W  = $clog2(WIN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  win_pos
);

  localparam int ACC_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);
  localparam logic [1:0] MODE_AVG = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;

  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic                    first;
  logic                    last;
  logic                    accept;
  logic [1:0]              use_mode;
  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] upd;
  logic [DATA_W-1:0]       res;

  // Only the window-completing sample waits for a stalled result
  always_comb begin
    first    = (count_q == '0);
    last     = (count_q == LAST);
    in_ready = !clear
               && !(last && out_valid_q && !out_ready);
    accept   = in_valid && in_ready;
  end

  // Fold the incoming sample into the window using the latched mode
  always_comb begin
    sx       = {{CNT_W{in_data[DATA_W-1]}}, in_data};
    use_mode = first ? mode : mode_q;
    upd      = sx;
    if (!first) begin
      case (use_mode)
        MODE_AVG: upd = acc_q + sx;
        MODE_MIN: upd = (sx <= acc_q) ? sx : acc_q;
        default:  upd = (sx >= acc_q) ? sx : acc_q;
      endcase
    end
    if (use_mode == MODE_AVG) begin
      res = DATA_W'(upd >>> CNT_W);
    end else begin
      res = upd[DATA_W-1:0];
    end
  end

  // Next-state for window position, accumulator and latched mode
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    if (clear) begin
      count_d = '0;
      acc_d   = '0;
    end else if (accept) begin
      acc_d   = upd;
      count_d = last ? '0 : count_q + CNT_W'(1);
      if (first) begin
        mode_d = mode;
      end
    end
  end

  // Output register: new result wins over a same-cycle consume
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && last) begin
      out_data_d  = res;
      out_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      acc_q       <= '0;
      mode_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign win_pos   = count_q;

endmodule

// File: tb/tb_pool_unit.sv
// Bench for pool_unit: window table plus backpressure,
// clear and asynchronous reset sequences, scoreboard checked.
module tb_pool_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [1:0]  mode;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  win_pos;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] m0;
    logic [1:0] m1;
    int s0;
    int s1;
    int s2;
    int s3;
    int exp;
  } vec_t;

  vec_t vecs[9];

  pool_unit #(.DATA_W(16), .WIN(4)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .mode(mode),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .win_pos(win_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the next expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("result", int'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  task automatic drive(logic [1:0] m, int d, int pos);
    int n;
    logic ok;
    n = 0;
    mode = m;
    in_data = d[15:0];
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      if (ok) chk("win_pos", int'(win_pos), pos);
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic window(logic [1:0] m0, logic [1:0] m1,
                        int s0, int s1, int s2, int s3, int e);
    exp_q.push_back(e);
    drive(m0, s0, 0);
    drive(m1, s1, 1);
    drive(m1, s2, 2);
    drive(m1, s3, 3);
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b00, 3, -7, 12, 12, 12};
    vecs[1] = '{2'b01, 2'b01, 5, 6, 7, 9, 6};
    vecs[2] = '{2'b01, 2'b01, -1, -2, -2, -2, -2};
    vecs[3] = '{2'b01, 2'b01, 32767, 32767, 32767, 32767, 32767};
    vecs[4] = '{2'b10, 2'b00, -32768, 100, 5, 0, -32768};
    vecs[5] = '{2'b00, 2'b00, 1, -5, 8, 2, 8};
    vecs[6] = '{2'b11, 2'b11, -3, -9, -1, -4, -1};
    vecs[7] = '{2'b01, 2'b01, -8, -8, -8, -7, -8};
    vecs[8] = '{2'b10, 2'b01, 4, 2, 7, 3, 2};

    reset = 1'b1;
    clear = 1'b0;
    mode = 2'b00;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_win_pos", int'(win_pos), 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      window(vecs[i].m0, vecs[i].m1, vecs[i].s0, vecs[i].s1,
             vecs[i].s2, vecs[i].s3, vecs[i].exp);
      chk("lat_out_valid", int'(out_valid), 1);
      chk("wrap_win_pos", int'(win_pos), 0);
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk("one_cycle_valid", int'(out_valid), 0);
      end
    end

    // Backpressure: stalled result of 9 holds off only the 4th sample
    window(2'b00, 2'b00, 9, 1, 2, 3, 9);
    out_ready = 1'b0;
    exp_q.push_back(20);
    drive(2'b00, 1, 0);
    drive(2'b00, 2, 1);
    drive(2'b00, 3, 2);
    in_data = 16'd20;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold_data", int'(out_data), 9);
      chk("bp_hold_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_valid", int'(out_valid), 1);
    chk("bp_new_data", int'(out_data), 20);
    @(posedge clk);
    #1;

    // Clear drops the partial window and the sample offered with it
    drive(2'b00, 50, 0);
    drive(2'b00, 60, 1);
    in_data = 16'd999;
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_win_pos", int'(win_pos), 0);
    window(2'b01, 2'b01, 4, -4, 7, 1, 2);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a window
    drive(2'b00, 70, 0);
    drive(2'b00, 80, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_win_pos", int'(win_pos), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    window(2'b01, 2'b01, 10, 20, 30, 41, 25);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_unit.md
# pool_unit

Parametrised streaming pooling processing element for the CNN datapath. It consumes one signed feature-map sample per accepted beat and reduces every WIN consecutive samples to one result. The reduction is selectable per window: max, min or average. It uses a valid/ready handshake on both sides and holds its output under backpressure. It replaces the fixed 4-sample max-only pooling PE in the pooling layer array.

## Interface
- DATA_W, 16: signed sample and result width.
- WIN, 4: samples per window. Must be a power of two, 2..64.
- CNT_W, $clog2(WIN): width of the window position counter.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the partial window.
- mode  in  2  reduction select: 00 max, 01 avg, 10 min, 11 treated as max.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- out_data  out  DATA_W  signed pooled result.
- out_valid  out  1  out_data holds a completed window result.
- out_ready  in  1  downstream accepts out_data.
- win_pos  out  CNT_W  number of samples accepted in the current window.

## Operation
- Accept: a sample is accepted when in_valid && in_ready.
- Window state: count (0..WIN-1), acc (DATA_W+CNT_W bits, signed), win_mode.
- First sample of a window (count==0):
  - mode is latched into win_mode.
  - acc loads the sample, sign-extended.
  - A mode change mid-window has no effect until the next window.
- Later samples update acc by win_mode:
  - max: acc = (sample >= acc) ? sample : acc.
  - min: acc = (sample <= acc) ? sample : acc.
  - avg: acc = acc + sample. Full width, no overflow possible.
- On the WIN-th accepted sample, the result is computed from acc with the sample folded in:
  - max/min: the extreme value.
  - avg: arithmetic right shift of the sum by CNT_W. This rounds toward negative infinity.
- The result is written to the out_data register and out_valid is set. count returns to 0.
- Output register: out_valid stays high and out_data stays stable until out_valid && out_ready. It then clears, unless a new result is written in the same cycle, in which case out_valid stays high with the new data.
- in_ready = !clear && !(count==WIN-1 && out_valid && !out_ready).
  - Partial-window samples are accepted while a result is stalled.
  - Only the completing sample is held off.
- clear:
  - Sets count to 0 and discards acc.
  - Does not touch out_valid or out_data.
  - in_ready is low during clear, so no sample is taken in that cycle.
- reset: count, acc, win_mode, out_data and out_valid go to 0 immediately. A partial window and any pending result are lost.
- win_pos = count.

## Timing
- Reset values: out_valid 0, out_data 0, win_pos 0. in_ready is 1 once reset is deasserted and clear is low.
- Latency: out_valid rises 1 cycle after the clock edge that accepts the WIN-th sample.
- Throughput: one sample per cycle sustained when out_ready is held high. This gives one result every WIN cycles with no bubbles.
- in_ready depends combinationally on clear, out_ready and registered state. It has no path from in_valid.
- out_data and out_valid are registered outputs with no combinational input path.
- Simultaneous completing sample and out_ready:
  - The old result is consumed and the new result loads on the same edge.
  - out_valid stays 1.
- Reset asserted mid-window or mid-stall: all state clears asynchronously. The first accepted sample after release starts a fresh window.

## Test plan
- Max, WIN=4, mode=00, samples 3, -7, 12, 12 on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle, out_data=12, 1 cycle after the 4th accept; win_pos sequence 0,1,2,3,0.
- Avg rounding, mode=01:
  - Samples 5, 6, 7, 9 -> out_data=6 (sum 27 >>> 2).
  - Samples -1, -2, -2, -2 -> out_data=-2 (sum -7 >>> 2).
  - Samples 32767 ×4 -> out_data=32767, no overflow.
- Min and mode latch: mode=10 at the first sample, switched to 00 after it, samples -32768, 100, 5, 0 -> out_data=-32768. The next window uses max.
- Backpressure:
  - Hold out_ready=0 after a result of 9.
  - Feed the next window: 3 samples are accepted, then in_ready=0 while the 4th is presented and out_data stays 9.
  - Raise out_ready -> 9 consumed, the 4th sample is accepted that cycle, and the new result appears on the next cycle.
- Clear: 2 samples accepted, clear pulsed together with in_valid -> that sample is dropped and win_pos=0. The next 4 samples form a complete window.
- Reset mid-window: accept 2 samples, assert reset asynchronously between edges -> out_valid=0, out_data=0 and win_pos=0 immediately. After release, 4 samples give a correct result.
